// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared types and constants for the multicycle MIPS main control FSM:
// state encoding, opcodes, alu_op codes, alu_src_b / pc_src encodings,
// the control word struct and the I-type ALU helper functions.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (adds the illegal_op bit).
package mc_ctrl_pkg;

    localparam int MC_OPC_W   = 6;
    localparam int MC_ALUOP_W = 4;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMRD    = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWR    = 4'd5,
        ST_RTYPE_EX = 4'd6,
        ST_RTYPE_WB = 4'd7,
        ST_IALU_EX  = 4'd8,
        ST_IALU_WB  = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [MC_OPC_W-1:0] OP_R    = 6'h00;
    localparam logic [MC_OPC_W-1:0] OP_J    = 6'h02;
    localparam logic [MC_OPC_W-1:0] OP_BEQ  = 6'h04;
    localparam logic [MC_OPC_W-1:0] OP_BNE  = 6'h05;
    localparam logic [MC_OPC_W-1:0] OP_ADDI = 6'h08;
    localparam logic [MC_OPC_W-1:0] OP_SLTI = 6'h0A;
    localparam logic [MC_OPC_W-1:0] OP_ANDI = 6'h0C;
    localparam logic [MC_OPC_W-1:0] OP_ORI  = 6'h0D;
    localparam logic [MC_OPC_W-1:0] OP_LW   = 6'h23;
    localparam logic [MC_OPC_W-1:0] OP_SW   = 6'h2B;

    localparam logic [MC_ALUOP_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [MC_ALUOP_W-1:0] ALU_SUB   = 4'b0001;
    localparam logic [MC_ALUOP_W-1:0] ALU_RTYPE = 4'b0010;
    localparam logic [MC_ALUOP_W-1:0] ALU_AND   = 4'b0011;
    localparam logic [MC_ALUOP_W-1:0] ALU_OR    = 4'b0100;
    localparam logic [MC_ALUOP_W-1:0] ALU_SLT   = 4'b0101;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
`ifdef MC_ILLEGAL_TRAP_EN
        logic                  illegal_op;
`endif
        logic                  pc_write;
        logic                  pc_write_cond;
        logic                  pc_write_ne;
        logic                  iord;
        logic                  mem_read;
        logic                  mem_write;
        logic                  ir_write;
        logic                  reg_write;
        logic                  reg_dst;
        logic                  mem_to_reg;
        logic                  alu_src_a;
        logic [1:0]            alu_src_b;
        logic                  ext_zero;
        logic [MC_ALUOP_W-1:0] alu_op;
        logic [1:0]            pc_src;
        logic                  instr_done;
    } ctrl_t;

    // ALU operation for the immediate-ALU group; ADDI is the fallback.
    function automatic logic [MC_ALUOP_W-1:0] ialu_op(input logic [MC_OPC_W-1:0] opc);
        case (opc)
            OP_ANDI: ialu_op = ALU_AND;
            OP_ORI:  ialu_op = ALU_OR;
            OP_SLTI: ialu_op = ALU_SLT;
            default: ialu_op = ALU_ADD;
        endcase
    endfunction

    // Logical immediates are zero-extended, arithmetic ones sign-extended.
    function automatic logic ialu_zext(input logic [MC_OPC_W-1:0] opc);
        ialu_zext = (opc == OP_ANDI) || (opc == OP_ORI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
// Bundle between the main control FSM and the datapath.
//   master (controller): in opcode, mem_ready; out all strobes/selects.
//   slave  (datapath)  : the reverse.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (adds illegal_op).
interface multicycle_control_if #(
    parameter int OPC_W   = mc_ctrl_pkg::MC_OPC_W,
    parameter int ALUOP_W = mc_ctrl_pkg::MC_ALUOP_W
);
    logic [OPC_W-1:0]   opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               pc_write_ne;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic               ext_zero;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_src;
    logic               instr_done;
`ifdef MC_ILLEGAL_TRAP_EN
    logic               illegal_op;
`endif

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_write_ne, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               ext_zero, alu_op, pc_src, instr_done
`ifdef MC_ILLEGAL_TRAP_EN
             , illegal_op
`endif
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_write_ne, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               ext_zero, alu_op, pc_src, instr_done
`ifdef MC_ILLEGAL_TRAP_EN
             , illegal_op
`endif
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec
// Combinational control-word decoder: state + latched opcode -> strobes.
//   state     : current FSM state
//   opc       : latched opcode (opc_q)
//   mem_ready : qualifies the FETCH load strobes and the SW completion
//   ctrl      : full control word, all fields 0 unless set below
// Optional feature macro: MC_ILLEGAL_TRAP_EN (ILLEGAL raises illegal_op).
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t                state,
    input  logic [MC_OPC_W-1:0]   opc,
    input  logic                  mem_ready,
    output ctrl_t                 ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                // IR and PC only load once memory delivers the word.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // Branch target precomputed into ALUOut.
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_RTYPE;
            end
            ST_RTYPE_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_IALU_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ialu_op(opc);
                ctrl.ext_zero  = ialu_zext(opc);
            end
            ST_IALU_WB: begin
                // ALU controls held so the result path stays stable during writeback.
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                ctrl.alu_op     = ialu_op(opc);
                ctrl.ext_zero   = ialu_zext(opc);
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
                ctrl.pc_write_cond = (opc == OP_BEQ);
                ctrl.pc_write_ne   = (opc == OP_BNE);
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ST_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
                ctrl.illegal_op = 1'b1;
`else
                ctrl.instr_done = 1'b1;
`endif
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM of the multicycle MIPS datapath.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : multicycle_control_if.master (opcode, mem_ready in;
//                all datapath strobes, mux selects and alu_op out)
// Holds the state register, the latched opcode and next-state logic; the
// control word comes from mc_ctrl_outdec and is forced to 0 while rst_n=0.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (illegal opcodes trap
// permanently and raise illegal_op; otherwise they retire as a NOP).
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_if.master  bus
);
    state_t                state_q, state_d;
    logic [MC_OPC_W-1:0]   opc_q, opc_d;
    ctrl_t                 ctrl, ctrl_g;

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        case (state_q)
            ST_FETCH:  if (bus.mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                // opc_q is loaded this cycle, so branch on the live opcode.
                opc_d = bus.opcode;
                case (bus.opcode)
                    OP_LW, OP_SW:                     state_d = ST_MEMADR;
                    OP_R:                             state_d = ST_RTYPE_EX;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = ST_IALU_EX;
                    OP_BEQ, OP_BNE:                   state_d = ST_BRANCH;
                    OP_J:                             state_d = ST_JUMP;
                    default:                          state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR:   state_d = (opc_q == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:    if (bus.mem_ready) state_d = ST_MEMWB;
            ST_MEMWR:    if (bus.mem_ready) state_d = ST_FETCH;
            ST_RTYPE_EX: state_d = ST_RTYPE_WB;
            ST_IALU_EX:  state_d = ST_IALU_WB;
            ST_MEMWB, ST_RTYPE_WB, ST_IALU_WB, ST_BRANCH, ST_JUMP:
                         state_d = ST_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            ST_ILLEGAL:  state_d = ST_ILLEGAL;
`else
            ST_ILLEGAL:  state_d = ST_FETCH;
`endif
            default:     state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state     (state_q),
        .opc       (opc_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    // Keep memory and register file quiet for the whole reset window.
    assign ctrl_g = rst_n ? ctrl : '0;

    assign bus.pc_write      = ctrl_g.pc_write;
    assign bus.pc_write_cond = ctrl_g.pc_write_cond;
    assign bus.pc_write_ne   = ctrl_g.pc_write_ne;
    assign bus.iord          = ctrl_g.iord;
    assign bus.mem_read      = ctrl_g.mem_read;
    assign bus.mem_write     = ctrl_g.mem_write;
    assign bus.ir_write      = ctrl_g.ir_write;
    assign bus.reg_write     = ctrl_g.reg_write;
    assign bus.reg_dst       = ctrl_g.reg_dst;
    assign bus.mem_to_reg    = ctrl_g.mem_to_reg;
    assign bus.alu_src_a     = ctrl_g.alu_src_a;
    assign bus.alu_src_b     = ctrl_g.alu_src_b;
    assign bus.ext_zero      = ctrl_g.ext_zero;
    assign bus.alu_op        = ctrl_g.alu_op;
    assign bus.pc_src        = ctrl_g.pc_src;
    assign bus.instr_done    = ctrl_g.instr_done;
`ifdef MC_ILLEGAL_TRAP_EN
    assign bus.illegal_op    = ctrl_g.illegal_op;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Scoreboard bench for multicycle_control: each cycle the expected output
// word is pushed when inputs are driven, then popped and compared against
// the DUT outputs at the falling edge.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (trap variant of illegal test).
module tb_multicycle_control;

    // Expected-state names used by the output model.
    localparam int T_RST = 0,  T_FETCH = 1, T_DEC = 2,  T_MADR = 3,
                   T_MRD = 4,  T_MWB = 5,   T_MWR = 6,  T_REX = 7,
                   T_RWB = 8,  T_IEX = 9,   T_IWB = 10, T_BR = 11,
                   T_JMP = 12, T_ILL = 13;

    typedef struct packed {
        logic       ill;
        logic       pcw, pcwc, pcwne, iord, mrd, mwr, irw, rw, rdst, m2r, srca;
        logic [1:0] srcb;
        logic       ezero;
        logic [3:0] aop;
        logic [1:0] pcsrc;
        logic       done;
    } ow_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int        n_chk  = 0;
    int        n_fail = 0;
    ow_t       sb[$];
    logic [5:0] cur_opc;
    ow_t       obs;

    always_comb begin
        obs = '0;
`ifdef MC_ILLEGAL_TRAP_EN
        obs.ill = bus.illegal_op;
`endif
        obs.pcw   = bus.pc_write;
        obs.pcwc  = bus.pc_write_cond;
        obs.pcwne = bus.pc_write_ne;
        obs.iord  = bus.iord;
        obs.mrd   = bus.mem_read;
        obs.mwr   = bus.mem_write;
        obs.irw   = bus.ir_write;
        obs.rw    = bus.reg_write;
        obs.rdst  = bus.reg_dst;
        obs.m2r   = bus.mem_to_reg;
        obs.srca  = bus.alu_src_a;
        obs.srcb  = bus.alu_src_b;
        obs.ezero = bus.ext_zero;
        obs.aop   = bus.alu_op;
        obs.pcsrc = bus.pc_src;
        obs.done  = bus.instr_done;
    end

    // Output table written from the state descriptions.
    function automatic ow_t expw(input int st, input logic [5:0] opc, input logic rdy);
        ow_t w;
        w = '0;
        case (st)
            T_FETCH: begin w.mrd = 1; w.srcb = 2'b01; w.irw = rdy; w.pcw = rdy; end
            T_DEC:   begin w.srcb = 2'b11; end
            T_MADR:  begin w.srca = 1; w.srcb = 2'b10; end
            T_MRD:   begin w.iord = 1; w.mrd = 1; end
            T_MWB:   begin w.rw = 1; w.m2r = 1; w.done = 1; end
            T_MWR:   begin w.iord = 1; w.mwr = 1; w.done = rdy; end
            T_REX:   begin w.srca = 1; w.aop = 4'b0010; end
            T_RWB:   begin w.rw = 1; w.rdst = 1; w.done = 1; end
            T_IEX, T_IWB: begin
                if (st == T_IEX) begin w.srca = 1; w.srcb = 2'b10; end
                else begin w.rw = 1; w.done = 1; end
                case (opc)
                    6'h0C:   begin w.aop = 4'b0011; w.ezero = 1; end
                    6'h0D:   begin w.aop = 4'b0100; w.ezero = 1; end
                    6'h0A:   w.aop = 4'b0101;
                    default: w.aop = 4'b0000;
                endcase
            end
            T_BR: begin
                w.srca = 1; w.aop = 4'b0001; w.pcsrc = 2'b01; w.done = 1;
                w.pcwc  = (opc == 6'h04);
                w.pcwne = (opc == 6'h05);
            end
            T_JMP: begin w.pcw = 1; w.pcsrc = 2'b10; w.done = 1; end
`ifdef MC_ILLEGAL_TRAP_EN
            T_ILL: w.ill = 1;
`else
            T_ILL: w.done = 1;
`endif
            default: ;
        endcase
        return w;
    endfunction

    task automatic chk(input string tag, input ow_t got, input ow_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive, push expectation, sample at negedge, pop and compare.
    task automatic cyc(input int st, input logic rdy, input string tag);
        ow_t e;
        bus.mem_ready = rdy;
        sb.push_back(expw(st, cur_opc, rdy));
        @(negedge clk);
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk(tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [5:0] opc);
        cur_opc    = opc;
        bus.opcode = opc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        set_op(6'h00);
        #1;
        cyc(T_RST, 1, "rst.0");
        cyc(T_RST, 1, "rst.1");
        rst_n = 1'b1;

        // LW, no stalls: 5 cycles
        set_op(6'h23);
        cyc(T_FETCH, 1, "lw.fetch"); cyc(T_DEC, 1, "lw.dec");
        cyc(T_MADR, 1, "lw.madr");   cyc(T_MRD, 1, "lw.mrd");
        cyc(T_MWB, 1, "lw.mwb");

        // ANDI; opcode goes to garbage after DECODE and must be ignored
        set_op(6'h0C);
        cyc(T_FETCH, 1, "andi.fetch"); cyc(T_DEC, 1, "andi.dec");
        bus.opcode = 6'h3F;
        cyc(T_IEX, 1, "andi.ex");      cyc(T_IWB, 1, "andi.wb");

        // ADDI, ORI, SLTI
        set_op(6'h08);
        cyc(T_FETCH, 1, "addi.fetch"); cyc(T_DEC, 1, "addi.dec");
        cyc(T_IEX, 1, "addi.ex");      cyc(T_IWB, 1, "addi.wb");
        set_op(6'h0D);
        cyc(T_FETCH, 1, "ori.fetch");  cyc(T_DEC, 1, "ori.dec");
        cyc(T_IEX, 1, "ori.ex");       cyc(T_IWB, 1, "ori.wb");
        set_op(6'h0A);
        cyc(T_FETCH, 1, "slti.fetch"); cyc(T_DEC, 1, "slti.dec");
        cyc(T_IEX, 1, "slti.ex");      cyc(T_IWB, 1, "slti.wb");

        // BNE: back in FETCH at cycle 4 (next instruction's fetch)
        set_op(6'h05);
        cyc(T_FETCH, 1, "bne.fetch"); cyc(T_DEC, 1, "bne.dec");
        cyc(T_BR, 1, "bne.br");

        // BEQ with two FETCH stalls
        set_op(6'h04);
        cyc(T_FETCH, 0, "beq.fstall0"); cyc(T_FETCH, 0, "beq.fstall1");
        cyc(T_FETCH, 1, "beq.fetch");   cyc(T_DEC, 1, "beq.dec");
        cyc(T_BR, 1, "beq.br");

        // R-type; mem_ready low in DECODE/EX must be ignored
        set_op(6'h00);
        cyc(T_FETCH, 1, "r.fetch"); cyc(T_DEC, 0, "r.dec");
        cyc(T_REX, 0, "r.ex");      cyc(T_RWB, 1, "r.wb");

        // J
        set_op(6'h02);
        cyc(T_FETCH, 1, "j.fetch"); cyc(T_DEC, 1, "j.dec");
        cyc(T_JMP, 1, "j.jmp");

        // SW with 3 stall cycles in MEMWR: 7 cycles total
        set_op(6'h2B);
        cyc(T_FETCH, 1, "sw.fetch"); cyc(T_DEC, 1, "sw.dec");
        cyc(T_MADR, 1, "sw.madr");
        for (int i = 0; i < 3; i++) cyc(T_MWR, 0, $sformatf("sw.stall%0d", i));
        cyc(T_MWR, 1, "sw.mwr");

        // LW stalled in MEMRD, then reset mid-stall
        set_op(6'h23);
        cyc(T_FETCH, 1, "lwr.fetch"); cyc(T_DEC, 1, "lwr.dec");
        cyc(T_MADR, 1, "lwr.madr");   cyc(T_MRD, 0, "lwr.stall0");
        cyc(T_MRD, 0, "lwr.stall1");
        rst_n = 1'b0;
        cyc(T_RST, 0, "lwr.rst0");    cyc(T_RST, 0, "lwr.rst1");
        rst_n = 1'b1;
        set_op(6'h02);
        cyc(T_FETCH, 1, "post.fetch"); cyc(T_DEC, 1, "post.dec");
        cyc(T_JMP, 1, "post.jmp");

        // Undefined opcode 0x3F
        set_op(6'h3F);
        cyc(T_FETCH, 1, "ill.fetch"); cyc(T_DEC, 1, "ill.dec");
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 12; i++) cyc(T_ILL, 1, $sformatf("ill.trap%0d", i));
        rst_n = 1'b0;
        cyc(T_RST, 1, "ill.rst");
        rst_n = 1'b1;
`else
        cyc(T_ILL, 1, "ill.nop");
`endif
        set_op(6'h08);
        cyc(T_FETCH, 1, "end.fetch"); cyc(T_DEC, 1, "end.dec");
        cyc(T_IEX, 1, "end.ex");      cyc(T_IWB, 1, "end.wb");

        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath: it decodes the latched instruction opcode and walks each instruction through the fetch, decode, execute, memory and writeback steps. It drives every datapath strobe and mux select, and produces the 4-bit `alu_op` consumed by the ALU control decoder. It sits between the instruction register and the datapath, and stalls on a memory ready handshake.

## Interface
- `OPC_W`, 6: opcode width.
- `ALUOP_W`, 4: width of `alu_op`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 6: instr[31:26] from the instruction register; valid from the DECODE cycle onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `pc_write_ne` out 1 each: PC write strobes (unconditional, on zero, on not-zero).
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory read and write strobes.
- `ir_write` out 1: instruction register load.
- `reg_write`, `reg_dst`, `mem_to_reg` out 1 each: register-file write enable; destination select (1 = rd, 0 = rt); writeback data select (1 = MDR).
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = register B, 01 = const 4, 10 = extended immediate, 11 = extended immediate << 2.
- `ext_zero` out 1: 1 = zero-extend the immediate; 0 = sign-extend.
- `alu_op` out 4: 0000 ADD, 0001 SUB, 0010 R-type (use funct), 0011 AND, 0100 OR, 0101 SLT.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: high in the final cycle of each instruction.
- `illegal_op` out 1: undefined opcode trapped; present only with the macro enabled.

## Operation
- **Supported opcodes:** R 0x00, J 0x02, BEQ 0x04, BNE 0x05, ADDI 0x08, SLTI 0x0A, ANDI 0x0C, ORI 0x0D, LW 0x23, SW 0x2B.
- **Output decode:** Moore outputs are decoded from the state register and the opcode register `opc_q`. `opc_q` is loaded from `opcode` in DECODE.
- **Default outputs:** every output not listed for a state is 0.

States and outputs:
- **FETCH:** mem_read=1, alu_src_b=01, alu_op=0000. ir_write and pc_write equal mem_ready. Stay in FETCH while mem_ready=0; otherwise go to DECODE.
- **DECODE:** alu_src_b=11, alu_op=0000 (precomputes the branch target). Next state by opcode:
  - LW/SW → MEMADR
  - R → RTYPE_EX
  - ADDI/SLTI/ANDI/ORI → IALU_EX
  - BEQ/BNE → BRANCH
  - J → JUMP
  - other → ILLEGAL
- **MEMADR:** alu_src_a=1, alu_src_b=10, alu_op=0000. LW → MEMRD; SW → MEMWR.
- **MEMRD:** iord=1, mem_read=1. Hold until mem_ready, then go to MEMWB.
- **MEMWB:** reg_write=1, mem_to_reg=1, instr_done=1. Next: FETCH.
- **MEMWR:** iord=1, mem_write=1. Hold until mem_ready; in the cycle mem_ready=1, instr_done=1 and next is FETCH.
- **RTYPE_EX:** alu_src_a=1, alu_op=0010. Next: RTYPE_WB.
- **RTYPE_WB:** reg_write=1, reg_dst=1, instr_done=1. Next: FETCH.
- **IALU_EX:** alu_src_a=1, alu_src_b=10.
  - alu_op: ADDI 0000, ANDI 0011, ORI 0100, SLTI 0101.
  - ext_zero=1 for ANDI/ORI only.
  - Next: IALU_WB.
- **IALU_WB:** reg_write=1, reg_dst=0, instr_done=1. ext_zero and alu_op are held as in IALU_EX. Next: FETCH.
- **BRANCH:** alu_src_a=1, alu_op=0001, pc_src=01, instr_done=1. pc_write_cond=1 for BEQ; pc_write_ne=1 for BNE. Next: FETCH.
- **JUMP:** pc_write=1, pc_src=10, instr_done=1. Next: FETCH.
- **ILLEGAL:** see Configuration.

## Timing
- **Reset:** `rst_n` is sampled low at a rising edge. The state register becomes FETCH and `opc_q` becomes 0. A reset in any state, including mid-stall, aborts the instruction.
- **Outputs while reset is asserted:** while rst_n=0, every output is forced to 0 combinationally, including mem_read and `illegal_op`.
- **Cycle counts with mem_ready tied to 1:** R 4, I-ALU 4, SW 4, LW 5, BEQ/BNE 3, J 3.
- **Stalls:** each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
  - No strobe other than mem_read/mem_write is asserted during a stall.
  - mem_read/mem_write stay asserted and iord stays stable.
  - A mem_ready that is high in any other state is ignored.
- **Opcode changes:** `opcode` changing after DECODE has no effect, because decode uses `opc_q`.

## Configuration
- **`MC_ILLEGAL_TRAP_EN` defined:**
  - ILLEGAL is a terminal state: `illegal_op`=1, all strobes 0, instr_done=0.
  - The FSM stays there until rst_n=0.
- **`MC_ILLEGAL_TRAP_EN` undefined:**
  - ILLEGAL behaves as a NOP: one cycle with instr_done=1 and all strobes 0, then FETCH.
  - The `illegal_op` port does not exist.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state encoding constants;
  - the opcode constants;
  - the alu_op constants (ADD/SUB/RTYPE/AND/OR/SLT);
  - the alu_src_b and pc_src encodings.
- One sub-module, `mc_ctrl_outdec`: purely combinational state+opc_q → control word decoder.
- The top level keeps the state register, `opc_q`, the next-state logic and the reset gating.

## Test plan
- **LW** (opcode 0x23), mem_ready=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 with mem_to_reg=1 in cycle 5; instr_done in cycle 5 only.
- **ANDI** (0x0C) → IALU_EX with alu_op=0011, ext_zero=1, alu_src_b=10; IALU_WB has reg_write=1, reg_dst=0. **ADDI** (0x08) gives alu_op=0000, ext_zero=0.
- **BNE** (0x05) → BRANCH with pc_write_ne=1, pc_write_cond=0, alu_op=0001, pc_src=01; back in FETCH at cycle 4.
- **SW** (0x2B) with mem_ready low for 3 cycles in MEMWR → mem_write high for 4 cycles, iord=1 throughout, total 7 cycles.
- **Opcode 0x3F:**
  - With `MC_ILLEGAL_TRAP_EN`: illegal_op=1 from cycle 3 and stays high for 10+ cycles.
  - Without it: NOP, FETCH again at cycle 4.
- **rst_n low during a MEMRD stall** → all outputs 0 during reset; FETCH with mem_read=1 on the first cycle after release.
